// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the UART transmitter: queues bus writes and launches them one at a time.
// Optional clear-to-send gating is compiled in with the UART_TX_CTS_EN macro.
module uart_tx_feeder #(
  parameter int DBIT = 8,
  parameter int AW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_din,
  input  logic            tx_done_tick,
  output logic            busy
`ifdef UART_TX_CTS_EN
  ,
  input  logic            cts_n
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DBIT-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count_nxt;
  logic            push, pop, cts_ok;

`ifdef UART_TX_CTS_EN
  logic cts_s1, cts_s2;

  // Synchronizer resets to "not clear" so nothing launches before the line settles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cts_s1 <= 1'b1;
      cts_s2 <= 1'b1;
    end else begin
      cts_s1 <= cts_n;
      cts_s2 <= cts_s1;
    end
  end

  assign cts_ok = ~cts_s2;
`else
  assign cts_ok = 1'b1;
`endif

  assign push = wr & ~full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && cts_ok) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (tx_done_tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Storage carries no reset; only pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      tx_din   <= '0;
    end else begin
      state    <= state_nxt;
      tx_start <= (state_nxt == START);
      busy     <= (state_nxt != IDLE);
      if (pop) tx_din <= mem[rd_ptr];
    end
  end

endmodule
